dmem_arbiter: RTL and testbench

- Shares the single data-memory BRAM port between two requesters: the CPU control path (load/store micro-steps) and the debug/program-loader port.
- Serialises accesses and hides the BRAM read latency behind a req/gnt/rvalid handshake.
- CPU has priority; a starvation guard bounds how long the debug port waits.
- Sits between the control/datapath and the data-memory BRAM; the control path holds in its load/store time step until gnt/rvalid.

---
 rtl/dmem_arb_pkg.sv | 31 +++
 rtl/dmem_arbiter_starve_counter.sv | 53 +++++
 rtl/dmem_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter:
//   - arbiter state encoding
//   - transaction owner encoding
//   - lowest legal values for the arbiter parameters
//   - counter width helper
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } arb_owner_e;

    localparam int RD_LAT_MIN   = 1;
    localparam int MAX_WAIT_MIN = 1;

    // Bits needed to hold any value in 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// arb_starve_counter
// Saturating count of consecutive arbitrations lost by the debug port.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_all_n  in   synchronous active-low reset, clears the count
//   inc          in   debug lost an arbitration this cycle
//   clr          in   debug granted, or debug not requesting at a decision
//   sat          out  count has reached MAX_WAIT
// -----------------------------------------------------------------------------
module arb_starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_all_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CNT_W = cnt_width(MAX_WAIT);

    if (MAX_WAIT < MAX_WAIT_MIN) begin : g_bad_max_wait
        $error("arb_starve_counter: MAX_WAIT must be at least 1");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sat = (cnt_q == CNT_W'(MAX_WAIT));

    // Clear wins over increment; the count holds once saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_all_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory BRAM port between the CPU control path and
// the debug/program-loader port. One transaction is outstanding at a time;
// the CPU has priority, and the debug port wins once it has lost MAX_WAIT
// consecutive arbitrations. All outputs are registered.
//
// Ports:
//   clk, reset_all_n                 clock, synchronous active-low reset
//   cpu_req/we/addr/wdata            CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata   CPU accept pulse, read-valid pulse, data
//   dbg_*                            same set for the debug/loader port
//   mem_en/we/addr/wdata             BRAM port controls
//   mem_rdata                        BRAM read data, RD_LAT cycles after mem_en
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | sample requests, pick a winner, latch its command
// ISSUE | mem_en and owner's gnt high for one cycle
// WAIT  | read in flight, lat_cnt counts down to the data-valid cycle
// RESP  | owner's rdata updated, owner's rvalid high for one cycle
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_all_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int LAT_W = cnt_width(RD_LAT);

    if (RD_LAT < RD_LAT_MIN) begin : g_bad_rd_lat
        $error("dmem_arbiter: RD_LAT must be at least 1");
    end

    arb_state_e    state_q,      state_d;
    arb_owner_e    owner_q,      owner_d;
    logic          we_q,         we_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;

    logic          cpu_gnt_q,    cpu_gnt_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic [DW-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic          dbg_gnt_q,    dbg_gnt_d;
    logic          dbg_rvalid_q, dbg_rvalid_d;
    logic [DW-1:0] dbg_rdata_q,  dbg_rdata_d;
    logic          mem_en_q,     mem_en_d;
    logic          mem_we_q,     mem_we_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic [DW-1:0] mem_wdata_q,  mem_wdata_d;

    logic starve_inc;
    logic starve_clr;
    logic starve_sat;
    logic dbg_wins;
    logic win_we;

    arb_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk         (clk),
        .reset_all_n (reset_all_n),
        .inc         (starve_inc),
        .clr         (starve_clr),
        .sat         (starve_sat)
    );

    assign dbg_wins = dbg_req && (!cpu_req || starve_sat);
    assign win_we   = dbg_wins ? dbg_we : cpu_we;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        lat_cnt_d    = lat_cnt_q;
        cpu_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_gnt_d    = 1'b0;
        dbg_rvalid_d = 1'b0;
        dbg_rdata_d  = dbg_rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        starve_inc   = 1'b0;
        starve_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                // Starvation bookkeeping happens only on IDLE decisions.
                starve_clr = !dbg_req || dbg_wins;
                starve_inc = dbg_req && !dbg_wins;
                if (cpu_req || dbg_req) begin
                    owner_d     = dbg_wins ? OWN_DBG : OWN_CPU;
                    we_d        = win_we;
                    mem_addr_d  = dbg_wins ? dbg_addr  : cpu_addr;
                    mem_wdata_d = dbg_wins ? dbg_wdata : cpu_wdata;
                    mem_en_d    = 1'b1;
                    mem_we_d    = win_we;
                    cpu_gnt_d   = !dbg_wins;
                    dbg_gnt_d   = dbg_wins;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d   = WAIT;
                    lat_cnt_d = LAT_W'(RD_LAT - 1);
                end
            end

            // mem_rdata is valid during the WAIT cycle where lat_cnt is 0,
            // so it is captured on the edge that enters RESP.
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = RESP;
                    if (owner_q == OWN_DBG) begin
                        dbg_rdata_d  = mem_rdata;
                        dbg_rvalid_d = 1'b1;
                    end else begin
                        cpu_rdata_d  = mem_rdata;
                        cpu_rvalid_d = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_all_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            we_q         <= 1'b0;
            lat_cnt_q    <= '0;
            cpu_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_gnt_q    <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            lat_cnt_q    <= lat_cnt_d;
            cpu_gnt_q    <= cpu_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_gnt_q    <= dbg_gnt_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_gnt    = dbg_gnt_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios plus randomized traffic against a transaction-level
// reference: each accepted request is scheduled as a set of expected events
// (gnt and mem access in the cycle after the decision, rvalid RD_LAT+1 cycles
// after that for reads), with a shadow memory supplying read data.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;
    localparam int NW       = 4096;
    localparam int MSZ      = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_all_n;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .AW (AW), .DW (DW), .RD_LAT (RD_LAT), .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk), .reset_all_n (reset_all_n),
        .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
        .cpu_gnt (cpu_gnt), .cpu_rvalid (cpu_rvalid), .cpu_rdata (cpu_rdata),
        .dbg_req (dbg_req), .dbg_we (dbg_we), .dbg_addr (dbg_addr), .dbg_wdata (dbg_wdata),
        .dbg_gnt (dbg_gnt), .dbg_rvalid (dbg_rvalid), .dbg_rdata (dbg_rdata),
        .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ (32'(a) * 32'h9E37_79B1);
    endfunction

    // BRAM model: read data appears RD_LAT cycles after the enable cycle;
    // every other cycle the pipe carries noise.
    logic [DW-1:0] bram    [MSZ];
    bit            bram_wr [MSZ];
    logic [DW-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            bram[mem_addr]    <= mem_wdata;
            bram_wr[mem_addr] <= 1'b1;
        end
        rd_pipe[0] <= (mem_en && !mem_we)
                      ? (bram_wr[mem_addr] ? bram[mem_addr] : init_val(mem_addr))
                      : $urandom;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Reference model state
    bit            e_cg [NW], e_dg [NW], e_crv [NW], e_drv [NW];
    bit            e_en [NW], e_we [NW], e_rst [NW];
    logic [DW-1:0] e_rdat [NW];
    logic [DW-1:0] shadow [MSZ];
    int            free_at, lost, cyc;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_crd, m_drd;

    int n_cmp = 0, n_err = 0;
    int n_cg, n_dg, n_crv, n_drv, n_en;
    int w_cg, w_dg, w_crv, w_drv;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int k);
        bit            dw;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            r;
        if (!reset_all_n) begin
            for (int w = k; w < k + RD_LAT + 4; w++) begin
                e_cg[w] = 0; e_dg[w] = 0; e_crv[w] = 0; e_drv[w] = 0;
                e_en[w] = 0; e_we[w] = 0;
            end
            e_rst[k] = 1;
            free_at  = k + 1;
            lost     = 0;
            m_addr   = '0;
            m_wd     = '0;
        end else if (k >= free_at) begin
            if (cpu_req || dbg_req) begin
                dw = dbg_req && (!cpu_req || lost == MAX_WAIT);
                if (dw)           lost = 0;
                else if (dbg_req) lost = (lost < MAX_WAIT) ? lost + 1 : lost;
                else              lost = 0;
                we = dw ? dbg_we    : cpu_we;
                a  = dw ? dbg_addr  : cpu_addr;
                d  = dw ? dbg_wdata : cpu_wdata;
                if (dw) e_dg[k] = 1; else e_cg[k] = 1;
                e_en[k] = 1;
                e_we[k] = we;
                m_addr  = a;
                m_wd    = d;
                if (we) begin
                    shadow[a] = d;
                    free_at   = k + 2;
                end else begin
                    r = k + RD_LAT + 1;
                    if (dw) e_drv[r] = 1; else e_crv[r] = 1;
                    e_rdat[r] = shadow[a];
                    free_at   = k + RD_LAT + 3;
                end
            end else begin
                lost = 0;
            end
        end
    endtask

    task automatic check_window(input int k);
        if (e_rst[k]) begin m_crd = '0; m_drd = '0; end
        if (e_crv[k]) m_crd = e_rdat[k];
        if (e_drv[k]) m_drd = e_rdat[k];
        chk_eq($sformatf("cpu_gnt@%0d",    k), cpu_gnt,    e_cg[k]);
        chk_eq($sformatf("dbg_gnt@%0d",    k), dbg_gnt,    e_dg[k]);
        chk_eq($sformatf("cpu_rvalid@%0d", k), cpu_rvalid, e_crv[k]);
        chk_eq($sformatf("dbg_rvalid@%0d", k), dbg_rvalid, e_drv[k]);
        chk_eq($sformatf("mem_en@%0d",     k), mem_en,     e_en[k]);
        chk_eq($sformatf("mem_we@%0d",     k), mem_we,     e_we[k]);
        chk_eq($sformatf("mem_addr@%0d",   k), mem_addr,   m_addr);
        chk_eq($sformatf("mem_wdata@%0d",  k), mem_wdata,  m_wd);
        chk_eq($sformatf("cpu_rdata@%0d",  k), cpu_rdata,  m_crd);
        chk_eq($sformatf("dbg_rdata@%0d",  k), dbg_rdata,  m_drd);
        if (cpu_gnt)    begin n_cg++;  w_cg  = k; end
        if (dbg_gnt)    begin n_dg++;  w_dg  = k; end
        if (cpu_rvalid) begin n_crv++; w_crv = k; end
        if (dbg_rvalid) begin n_drv++; w_drv = k; end
        if (mem_en)     n_en++;
    endtask

    task automatic step();
        cyc++;
        model_edge(cyc);
        @(posedge clk);
        @(negedge clk);
        check_window(cyc);
    endtask

    task automatic step_until(input int sel, input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 16 && !hit; i++) begin
            step();
            case (sel)
                0:       hit = e_cg[cyc];
                1:       hit = e_dg[cyc];
                2:       hit = e_crv[cyc];
                default: hit = e_drv[cyc];
            endcase
        end
        if (!hit) chk_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        reset_all_n = 1'b0; step();
        reset_all_n = 1'b1;
    endtask

    task automatic new_req(output logic we, output logic [AW-1:0] a, output logic [DW-1:0] d);
        we = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        d  = $urandom;
    endtask

    int snap_a, snap_b, ngr;
    logic [5:0] order;
    bit c_rd_wait, d_rd_wait;

    initial begin
        for (int i = 0; i < MSZ; i++) shadow[i] = init_val(AW'(i));
        cyc = 0; free_at = 0; lost = 0;
        m_addr = '0; m_wd = '0; m_crd = '0; m_drd = '0;
        n_cg = 0; n_dg = 0; n_crv = 0; n_drv = 0; n_en = 0;
        reset_all_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;

        // Reset, then idle with no requests
        step(); step();
        reset_all_n = 1'b1;
        snap_a = n_en;
        for (int i = 0; i < 10; i++) step();
        chk_eq("idle_no_mem_en", n_en - snap_a, 0);
        chk_eq("idle_outputs", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en, mem_we,
                                mem_addr, cpu_rdata, dbg_rdata}, '0);

        // CPU write then read back at 0x005
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h005; cpu_wdata = 32'hDEAD_BEEF;
        step();
        chk_eq("wr_gnt_en_we", {cpu_gnt, mem_en, mem_we}, 3'b111);
        cpu_req = 0;
        step();
        cpu_req = 1; cpu_we = 0;
        w_cg = -100; w_crv = -100;
        step_until(0, "rd_gnt");
        cpu_req = 0;
        step_until(2, "rd_rvalid");
        chk_eq("rd_latency", 64'(w_crv - w_cg), 3);
        chk_eq("rd_data", cpu_rdata, 32'hDEAD_BEEF);

        // Starvation guard: CPU writes back to back, debug write held
        do_reset();
        step();
        cpu_req = 1; cpu_we = 1; cpu_addr = AW'($urandom); cpu_wdata = $urandom;
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h100; dbg_wdata = 32'h0BAD_F00D;
        ngr = 0; order = '0;
        for (int i = 0; i < 40 && ngr < 6; i++) begin
            step();
            if (cpu_gnt || dbg_gnt) begin order = {order[4:0], dbg_gnt}; ngr++; end
            if (e_cg[cyc]) begin cpu_addr = AW'($urandom); cpu_wdata = $urandom; end
            if (e_dg[cyc]) dbg_req = 0;
        end
        chk_eq("starve_grants", ngr, 6);
        chk_eq("starve_order", order, 6'b000010);
        cpu_req = 0; dbg_req = 0;
        step(); step();

        // Debug read of 0x3FF, CPU request arrives during WAIT
        do_reset();
        w_cg = -100; w_drv = -100;
        dbg_req = 1; dbg_we = 0; dbg_addr = 10'h3FF;
        step_until(1, "dbg_rd_gnt");
        dbg_req = 0;
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
        step_until(0, "cpu_after_dbg_gnt");
        cpu_req = 0;
        chk_eq("dbg_rvalid_first", 64'(w_cg - w_drv), 2);
        step_until(2, "cpu_after_dbg_rvalid");
        chk_eq("dbg_rdata_val", dbg_rdata, init_val(10'h3FF));
        chk_eq("cpu_rdata_val", cpu_rdata, init_val(10'h010));

        // Reset during WAIT of a CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
        step_until(0, "rst_rd_gnt");
        cpu_req = 0;
        step();
        snap_a = n_crv;
        do_reset();
        for (int i = 0; i < 6; i++) step();
        chk_eq("rst_no_rvalid", n_crv - snap_a, 0);
        chk_eq("rst_rdata_cleared", cpu_rdata, 0);
        cpu_req = 1;
        step_until(0, "rst_recover_gnt");
        cpu_req = 0;
        step_until(2, "rst_recover_rvalid");
        chk_eq("rst_recover_cnt", n_crv - snap_a, 1);
        chk_eq("rst_recover_data", cpu_rdata, 32'hDEAD_BEEF);

        // Debug request pulsed while busy and withdrawn before IDLE
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h006;
        step_until(0, "pulse_rd_gnt");
        cpu_req = 0;
        snap_a = n_dg; snap_b = n_en;
        step();
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h020; dbg_wdata = 32'h1234_5678;
        step();
        dbg_req = 0;
        for (int i = 0; i < 6; i++) step();
        chk_eq("pulse_no_dbg_gnt", n_dg - snap_a, 0);
        chk_eq("pulse_no_mem_access", n_en - snap_b, 0);

        // Randomized traffic with withdrawals and occasional resets
        c_rd_wait = 0; d_rd_wait = 0;
        for (int i = 0; i < 2500; i++) begin
            reset_all_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            step();
            if (e_rst[cyc]) begin c_rd_wait = 0; d_rd_wait = 0; end
            if (e_crv[cyc]) c_rd_wait = 0;
            if (e_drv[cyc]) d_rd_wait = 0;

            if (cpu_req && e_cg[cyc]) begin
                if (!cpu_we) begin cpu_req = 0; c_rd_wait = 1; end
                else if ($urandom_range(0, 1) == 1) new_req(cpu_we, cpu_addr, cpu_wdata);
                else cpu_req = 0;
            end else if (cpu_req && $urandom_range(0, 19) == 0) begin
                cpu_req = 0;
            end else if (!cpu_req && !c_rd_wait && $urandom_range(0, 2) == 0) begin
                new_req(cpu_we, cpu_addr, cpu_wdata);
                cpu_req = 1;
            end

            if (dbg_req && e_dg[cyc]) begin
                if (!dbg_we) begin dbg_req = 0; d_rd_wait = 1; end
                else if ($urandom_range(0, 1) == 1) new_req(dbg_we, dbg_addr, dbg_wdata);
                else dbg_req = 0;
            end else if (dbg_req && $urandom_range(0, 19) == 0) begin
                dbg_req = 0;
            end else if (!dbg_req && !d_rd_wait && $urandom_range(0, 2) == 0) begin
                new_req(dbg_we, dbg_addr, dbg_wdata);
                dbg_req = 1;
            end
        end
        reset_all_n = 1'b1;
        cpu_req = 0; dbg_req = 0;
        for (int i = 0; i < 10; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
